lsu_seq: RTL

- Multi-cycle load/store sequencer for the integer core.
- Accepts one load/store from decode and configures the operand/immediate mux to produce the sign/zero-extended offset.
- Forms the effective address and runs a valid/ack transaction on the data-memory port.
- Returns lane-aligned, extended load data to writeback, or reports misaligned/illegal/timeout errors.

---
 rtl/lsu_seq.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/lsu_seq.sv
// Load/store sequencer: accepts one op from decode, forms the effective address, runs a valid/ack memory transaction, and returns extended load data.
// Latency: at least 4 cycles per op (IDLE accept, CHECK, REQ x N, FIN); REQ lasts until mem_ack or TIMEOUT cycles.
// Backpressure: issue_ready is high only in IDLE; mem_req is held with stable address/data/enables until mem_ack.
//
// Ports:
//   clock, reset                  rising-edge clock, asynchronous active-high reset
//   issue_valid/issue_ready       decode handshake; isStore, funct3, rs1, rs2, operand qualify it
//   immSample, D                  immediate-format select and register-pass select to the operand mux
//   mem_req/mem_ack               memory handshake; mem_we, mem_addr, mem_wdata, mem_be with it; mem_rdata with ack
//   wb_valid, wb_data             one-cycle extended load result
//   done                          one-cycle completion pulse for loads and stores
//   err, err_valid                error code (held until next accept) and its one-cycle pulse
module lsu_seq #(
  parameter int TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        isStore,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] operand,
  output logic [2:0]  immSample,
  output logic        D,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic        done,
  output logic [1:0]  err,
  output logic        err_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_REQ   = 2'd2;
  localparam logic [1:0] S_FIN   = 2'd3;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_ALIGN = 2'b01;
  localparam logic [1:0] E_ILL   = 2'b10;
  localparam logic [1:0] E_TMO   = 2'b11;

  // Last REQ cycle index before a missing ack turns into a timeout.
  localparam logic [7:0] TLIM = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [31:0] ea;
  logic [31:0] sdata;
  logic        st;
  logic [2:0]  f3;
  logic [2:0]  imm_q;
  logic [1:0]  err_q;
  logic [7:0]  timer;
  logic [31:0] rdata_q;
  logic        fin_to;

  logic [2:0]  imm_sel;
  logic        legal;
  logic        misal;
  logic [1:0]  chk_code;
  logic [3:0]  be_c;
  logic [31:0] wd_c;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_res;

  logic in_idle, in_check, in_req, in_fin;
  assign in_idle  = (state == S_IDLE);
  assign in_check = (state == S_CHECK);
  assign in_req   = (state == S_REQ);
  assign in_fin   = (state == S_FIN);

  // Immediate format for the mux: S-type for stores, otherwise I-type (unsigned variant for LBU/LHU).
  assign imm_sel = isStore ? 3'b010 : (funct3[2] ? 3'b001 : 3'b000);

  always_comb begin
    legal = 1'b0;
    if (st) begin
      legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    end else begin
      legal = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
              (f3 == 3'b100) || (f3 == 3'b101);
    end
  end

  assign misal = ((f3[1:0] == 2'b01) && ea[0]) ||
                 ((f3[1:0] == 2'b10) && (ea[1:0] != 2'b00));

  // An illegal width wins over misalignment.
  assign chk_code = !legal ? E_ILL : (misal ? E_ALIGN : E_NONE);

  always_comb begin
    be_c = 4'b1111;
    wd_c = sdata;
    case (f3[1:0])
      2'b00: begin
        be_c = 4'b0001 << ea[1:0];
        wd_c = {4{sdata[7:0]}};
      end
      2'b01: begin
        be_c = ea[1] ? 4'b1100 : 4'b0011;
        wd_c = {2{sdata[15:0]}};
      end
      default: begin
        be_c = 4'b1111;
        wd_c = sdata;
      end
    endcase
  end

  always_comb begin
    lane_b = rdata_q[7:0];
    case (ea[1:0])
      2'b00:   lane_b = rdata_q[7:0];
      2'b01:   lane_b = rdata_q[15:8];
      2'b10:   lane_b = rdata_q[23:16];
      default: lane_b = rdata_q[31:24];
    endcase
  end

  assign lane_h = ea[1] ? rdata_q[31:16] : rdata_q[15:0];

  // funct3[2] selects zero extension (LBU/LHU).
  always_comb begin
    load_res = rdata_q;
    case (f3[1:0])
      2'b00:   load_res = f3[2] ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_res = f3[2] ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_res = rdata_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      ea      <= '0;
      sdata   <= '0;
      st      <= 1'b0;
      f3      <= '0;
      imm_q   <= '0;
      err_q   <= E_NONE;
      timer   <= '0;
      rdata_q <= '0;
      fin_to  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Tracks the mux select so it is held after leaving IDLE.
          imm_q <= imm_sel;
          if (issue_valid) begin
            ea     <= rs1 + operand;
            sdata  <= rs2;
            st     <= isStore;
            f3     <= funct3;
            err_q  <= E_NONE;
            fin_to <= 1'b0;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (chk_code != E_NONE) begin
            err_q <= chk_code;
            state <= S_IDLE;
          end else begin
            timer <= '0;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            state   <= S_FIN;
          end else if (timer == TLIM) begin
            err_q  <= E_TMO;
            fin_to <= 1'b1;
            state  <= S_FIN;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Reset drives the mux to register-pass with immSample 0, overriding the IDLE values.
  assign issue_ready = in_idle;
  assign D           = reset | !in_idle;
  assign immSample   = reset ? 3'b000 : (in_idle ? imm_sel : imm_q);

  assign mem_req   = in_req;
  assign mem_we    = in_req & st;
  assign mem_addr  = in_req ? {ea[31:2], 2'b00} : 32'd0;
  assign mem_be    = in_req ? be_c : 4'd0;
  assign mem_wdata = (in_req && st) ? wd_c : 32'd0;

  assign wb_valid  = in_fin & !st & !fin_to;
  assign done      = in_fin & !fin_to;
  assign wb_data   = wb_valid ? load_res : 32'd0;

  assign err_valid = (in_check && (chk_code != E_NONE)) || (in_fin && fin_to);
  assign err       = in_check ? chk_code : err_q;

endmodule
